// File: rtl/dreg_pkg.sv
// Shared constants and helpers for the dreg_pipe elastic register pipeline.
package dreg_pkg;

    localparam int DREG_WIDTH = 8;
    localparam int DREG_DEPTH = 3;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dreg_pipe_stage.sv
// One pipeline stage: valid + data register that loads whenever it is ready.
module dreg_pipe_stage
    import dreg_pkg::*;
#(
    parameter int               WIDTH       = DREG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             stg_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // An empty stage always accepts, so bubbles collapse under back-pressure.
    assign stg_ready = !valid_q || dn_ready;
    assign valid     = valid_q;
    assign data      = data_q;

    // Next state: flush clears, otherwise load when ready; data only moves with a valid word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = RESET_VALUE;
        end else if (stg_ready) begin
            valid_d = up_valid;
            if (up_valid) data_d = up_data;
        end
    end

    // Stage register, discarded immediately on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dreg_pipe.sv
// WIDTH-bit, DEPTH-stage registered pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dreg_pipe
    import dreg_pkg::*;
#(
    parameter int               WIDTH       = DREG_WIDTH,
    parameter int               DEPTH       = DREG_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0]            up_valid;
    logic [DEPTH-1:0][WIDTH-1:0] up_data;
    logic [DEPTH:0]              rdy;
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

    logic          in_xfer, out_xfer;
    logic [OW-1:0] occ_d, occ_q;

    // Flush blocks the producer so the word offered that cycle is dropped.
    assign rdy[DEPTH]  = out_ready;
    assign in_ready    = rdy[0] && !flush;
    assign up_valid[0] = in_valid && !flush;
    assign up_data[0]  = in_data;

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            if (i > 0) begin : g_link
                assign up_valid[i] = vld_pipe[i-1];
                assign up_data[i]  = dat_pipe[i-1];
            end
            dreg_pipe_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .flush     (flush),
                .up_valid  (up_valid[i]),
                .up_data   (up_data[i]),
                .dn_ready  (rdy[i+1]),
                .stg_ready (rdy[i]),
                .valid     (vld_pipe[i]),
                .data      (dat_pipe[i])
            );
        end
    endgenerate

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign occupancy = occ_q;

    // Occupancy tracks accepted words; an output during flush is honoured but the count still clears.
    always_comb begin
        occ_d = occ_q;
        if (flush) occ_d = '0;
        else       occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
    end

    // Occupancy register, updated on the same edge as the stage valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) occ_q <= '0;
        else          occ_q <= occ_d;
    end

endmodule

// File: tb/tb_dreg_pipe.sv
// Directed bench for dreg_pipe with a queue scoreboard and an output monitor.
module tb_dreg_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    dreg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h5A)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got %0h expected no output", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  32'h5A);
        chk("rst_occ",       32'(occupancy), 0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single word latency: accepted at E0, visible after E2, gone after E3.
        out_ready = 1'b1;
        exp_q.push_back(8'hA1);
        in_valid = 1'b1; in_data = 8'hA1;
        step();
        in_valid = 1'b0;
        chk("single_occ_e0", 32'(occupancy), 1);
        chk("single_ov_e0",  32'(out_valid), 0);
        step();
        chk("single_ov_e1",  32'(out_valid), 0);
        step();
        chk("single_ov_e2",  32'(out_valid), 1);
        chk("single_od_e2",  32'(out_data),  32'hA1);
        step();
        chk("single_ov_e3",  32'(out_valid), 0);
        chk("single_occ_e3", 32'(occupancy), 0);

        // Mid-cycle asynchronous reset discards contents without a clock edge.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data",  32'(out_data),  32'h5A);
        chk("arst_occ",       32'(occupancy), 0);
        #2 reset_n = 1'b1;
        step();

        // Back-pressure: three words fill the pipe, the fourth waits for out_ready.
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
        in_valid = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_data = 8'h03; step();
        in_data = 8'h04;
        chk("bp_in_ready_full", 32'(in_ready),  0);
        chk("bp_occ_full",      32'(occupancy), 3);
        step();
        chk("bp_hold_in_ready", 32'(in_ready),  0);
        chk("bp_hold_occ",      32'(occupancy), 3);
        chk("bp_hold_head",     32'(out_data),  32'h01);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("bp_occ_swap", 32'(occupancy), 3);
        step(); step(); step();
        chk("bp_occ_drained", 32'(occupancy), 0);
        chk("bp_all_out",     32'(exp_q.size()), 0);

        // Streaming 16 words back to back with no back-pressure.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            exp_q.push_back(8'(i));
            chk("stream_in_ready", 32'(in_ready), 1);
            if (i == 2) chk("stream_ov_e1", 32'(out_valid), 0);
            if (i == 3) begin
                chk("stream_ov_e2", 32'(out_valid), 1);
                chk("stream_od_e2", 32'(out_data),  0);
            end
            step();
        end
        in_valid = 1'b0;
        chk("stream_occ_full", 32'(occupancy), 3);
        step(); step(); step();
        chk("stream_occ_end", 32'(occupancy), 0);
        chk("stream_all_out", 32'(exp_q.size()), 0);

        // Bubble collapse under back-pressure.
        out_ready = 1'b0;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        in_valid = 1'b1; in_data = 8'h11; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h22; step();
        in_valid = 1'b0; step();
        chk("bub_occ",       32'(occupancy), 2);
        chk("bub_in_ready",  32'(in_ready),  1);
        chk("bub_out_valid", 32'(out_valid), 1);
        chk("bub_out_data",  32'(out_data),  32'h11);
        in_valid = 1'b1; in_data = 8'h33; step();
        in_valid = 1'b0;
        chk("bub_occ_full",  32'(occupancy), 3);
        chk("bub_in_ready_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        step(); step(); step();
        chk("bub_occ_drained", 32'(occupancy), 0);
        chk("bub_all_out",     32'(exp_q.size()), 0);

        // Flush a full pipe while the consumer is ready.
        out_ready = 1'b0;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        in_valid = 1'b1;
        in_data = 8'hA0; step();
        in_data = 8'hA1; step();
        in_data = 8'hA2; step();
        in_data = 8'hEE;
        out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_head_only", 32'(exp_q.size()), 2);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_occ",       32'(occupancy), 0);
        chk("flush_out_data",  32'(out_data),  32'h5A);
        exp_q.delete();
        step(); step(); step();
        chk("flush_dropped", 32'(out_valid), 0);
        chk("flush_occ_end", 32'(occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dreg_pipe.md
Name: dreg_pipe

Overview:
- Parametrised successor to the team's single-bit D storage element: a WIDTH-bit, DEPTH-stage registered pipeline with valid/ready flow control.
- Every stage is an edge-triggered register; no latches.
- Adds per-stage valid tracking, back-pressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between producer/consumer blocks for timing isolation and elastic buffering.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 3, number of register stages. Legal range ≥1.
- RESET_VALUE, '0, value loaded into every data register on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  producer has data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  stage DEPTH-1 holds data.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous-safe deassert):
  - All valid bits = 0 and all data = RESET_VALUE.
  - out_valid=0, out_data=RESET_VALUE, occupancy=0.
  - in_ready follows its combinational equation (=1 once out of reset).
- Stage i holds v[i] and d[i]. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush.
- Upstream valid: u[0] = in_valid & !flush; u[i] = v[i-1].
- At each clk edge, if r[i]: v[i] <= u[i], and d[i] <= upstream data only when u[i]=1. Otherwise the stage holds.
- Bubbles collapse: an empty stage always accepts, even while out_ready=0.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur in the same cycle. A full pipe with out_ready=1 accepts a new word each cycle.
- Latency: word accepted at edge n appears on out_valid after edge n+DEPTH-1 (visible cycle n+DEPTH-1) when there is no back-pressure.
- Throughput: 1 word/cycle sustained.
- Full: all v=1 and out_ready=0 → in_ready=0. Data is held; no overwrite, no loss.
- Empty: out_valid=0. out_data keeps its last value (don't-care to the consumer).
- flush=1:
  - in_ready=0.
  - Next edge: all v <= 0 and d <= RESET_VALUE.
  - Any output transfer that cycle still counts (consumer handshake honoured); the input is dropped.
- Occupancy:
  - Registered count, updated at the same edge as v.
  - count' = count + in_xfer − out_xfer; 0 on flush and on reset.
  - Never exceeds DEPTH.
- Ordering is strictly FIFO. Data changes only on accepted transfers.
- Reset mid-operation: all contents are discarded immediately (asynchronous), regardless of handshakes in progress.

Decomposition:
- Package dreg_pkg holds:
  - function occ_width(depth) = $clog2(depth+1);
  - default constants DREG_WIDTH=8, DREG_DEPTH=3.
- One sub-module, dreg_pipe_stage (valid + data register with load = r[i], plus its r[i] equation), instantiated DEPTH times via generate.
- Occupancy counter and flush gating live in the top module.

Test Plan:
- Reset with WIDTH=8, DEPTH=3, RESET_VALUE=8'h5A: assert reset_n=0 mid-cycle → out_valid=0, out_data=8'h5A, occupancy=0 immediately, without waiting for a clock edge.
- Single word with out_ready=1: push 8'hA1 at edge 0 → out_valid=1 with out_data=8'hA1 after edge 2. It leaves at edge 3, then occupancy=0.
- Back-pressure with out_ready=0: offer 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles → 3 words accepted, in_ready=0 on the 4th, occupancy=3. Then set out_ready=1 → outputs 01, 02, 03 on consecutive cycles. 04 is accepted the cycle in_ready rises; no data is lost.
- Streaming: 16 words 0x00..0x0F with in_valid=1 and out_ready=1 → in_ready stays 1, and outputs appear in order, one per cycle, starting at cycle 2.
- Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22, all with out_ready=0 → both words pack into stages 2 and 1, occupancy=2, in_ready=1.
- Flush with full pipe and out_ready=1: assert flush for 1 cycle → in_ready=0 that cycle and the head word is delivered. Next cycle out_valid=0, occupancy=0, and the offered input word is never output.
